// File: rtl/millis_stopwatch_pkg.sv
// ============================================================================
// Module  : millis_stopwatch_pkg
// Purpose : Shared peripheral constants for the millisecond stopwatch:
//           register addresses, CTRL bit positions, FSM state encoding and
//           a CTRL-write decoder.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package millis_stopwatch_pkg;

  // Register map
  localparam logic [1:0] STOPWATCH_CTRL = 2'd0;
  localparam logic [1:0] STOPWATCH_LO   = 2'd1;
  localparam logic [1:0] STOPWATCH_HI   = 2'd2;

  // CTRL write bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_CLEAR   = 2;
  localparam int CTRL_OVF_CLR = 3;

  // FSM state encoding
  localparam logic [0:0] STOPPED = 1'b0;
  localparam logic [0:0] RUNNING = 1'b1;

  typedef struct packed {
    logic ovf_clr;
    logic clear;
    logic stop;
    logic start;
  } ctrl_cmd_t;

  // Only the low nibble of a CTRL write carries commands.
  function automatic ctrl_cmd_t decode_ctrl(input logic [3:0] wdata);
    ctrl_cmd_t cmd;
    cmd.start   = wdata[CTRL_START];
    cmd.stop    = wdata[CTRL_STOP];
    cmd.clear   = wdata[CTRL_CLEAR];
    cmd.ovf_clr = wdata[CTRL_OVF_CLR];
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/millis_stopwatch_if.sv
// ============================================================================
// Module  : millis_stopwatch_if
// Purpose : 8-bit peripheral bus bundle for the stopwatch.
// Ports   : addr     - register select (2 bits)
//           data_in  - write data (8 bits)
//           write_en - single-cycle write strobe
//           read_en  - single-cycle read strobe
//           data_out - combinational read data (8 bits)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface millis_stopwatch_if;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_out;

  modport master (output addr, data_in, write_en, read_en, input data_out);
  modport slave  (input addr, data_in, write_en, read_en, output data_out);
endinterface

`default_nettype wire

// File: rtl/millis_stopwatch_tick_gen.sv
// ============================================================================
// Module  : ms_tick_gen
// Purpose : Held/reloadable millisecond prescaler. Counts down while enabled,
//           emits a one-cycle tick at zero and reloads PRESCALE-1. When not
//           enabled the count is held so partial milliseconds are kept.
// Ports   : clk    - system clock
//           reset  - asynchronous active-low reset
//           enable - count while high (stopwatch RUNNING)
//           reload - force the count back to PRESCALE-1
//           tick   - one-cycle millisecond tick
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_tick_gen #(
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic enable,
  input  wire logic reload,
  output logic      tick
);

  localparam logic [15:0] RELOAD_VAL = PRESCALE - 16'd1;

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Tick is raised while the count sits at zero, so the first tick comes
  // PRESCALE cycles after enable rises from a freshly reloaded count.
  assign tick = enable && (count_q == 16'd0);

  always_comb begin
    count_d = count_q;
    if (reload || tick) begin
      count_d = RELOAD_VAL;
    end else if (enable) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RELOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/millis_stopwatch.sv
// ============================================================================
// Module  : millis_stopwatch
// Purpose : Elapsed-time peripheral counting whole milliseconds under
//           START/STOP/CLEAR software control, with a coherent LO/HI
//           snapshot read and a sticky overflow flag.
// Ports   : clk      - system clock
//           reset    - asynchronous active-low reset
//           bus      - peripheral bus (slave modport)
//           running  - high while in RUNNING
//           overflow - sticky 0xFFFF->0x0000 wrap flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module millis_stopwatch
  import millis_stopwatch_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  millis_stopwatch_if.slave  bus,
  output logic               running,
  output logic               overflow
);

  logic [0:0]  state_q,    state_d;
  logic [15:0] elapsed_q,  elapsed_d;
  logic [7:0]  snap_hi_q,  snap_hi_d;
  logic        overflow_q, overflow_d;

  ctrl_cmd_t cmd;
  logic      ctrl_wr;
  logic      lo_rd;
  logic      tick;
  logic      wrap;
  logic      data_in_unused;

  assign ctrl_wr        = bus.write_en && (bus.addr == STOPWATCH_CTRL);
  assign lo_rd          = bus.read_en  && (bus.addr == STOPWATCH_LO);
  assign data_in_unused = ^bus.data_in[7:4];

  always_comb begin
    cmd = '0;
    if (ctrl_wr) begin
      cmd = decode_ctrl(bus.data_in[3:0]);
    end
  end

  ms_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == RUNNING),
    .reload (cmd.clear),
    .tick   (tick)
  );

  // A wrap discarded by a simultaneous CLEAR must not raise the flag.
  assign wrap = tick && (elapsed_q == 16'hFFFF) && !cmd.clear;

  always_comb begin
    state_d = state_q;
    if (cmd.stop) begin
      state_d = STOPPED;
    end else if (cmd.start) begin
      state_d = RUNNING;
    end

    elapsed_d = elapsed_q;
    if (cmd.clear) begin
      elapsed_d = 16'd0;
    end else if (tick) begin
      elapsed_d = elapsed_q + 16'd1;
    end

    overflow_d = overflow_q;
    if (wrap) begin
      overflow_d = 1'b1;
    end else if (cmd.ovf_clr) begin
      overflow_d = 1'b0;
    end

    // Snapshot uses the pre-tick value so a LO/HI read pair stays coherent.
    snap_hi_d = snap_hi_q;
    if (lo_rd) begin
      snap_hi_d = elapsed_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= STOPPED;
      elapsed_q  <= 16'd0;
      snap_hi_q  <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      snap_hi_q  <= snap_hi_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = (state_q == RUNNING);
  assign overflow = overflow_q;

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.addr)
      STOPWATCH_CTRL: bus.data_out = {6'b0, overflow_q, running};
      STOPWATCH_LO:   bus.data_out = elapsed_q[7:0];
      STOPWATCH_HI:   bus.data_out = snap_hi_q;
      default:        bus.data_out = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_millis_stopwatch.sv
// ============================================================================
// Module  : tb_millis_stopwatch
// Purpose : Self-checking bench for millis_stopwatch (PRESCALE=4) with a
//           cycle-level behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_millis_stopwatch;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic running;
  logic overflow;

  millis_stopwatch_if bus ();

  millis_stopwatch #(.PRESCALE(16'd4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .running  (running),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: whole ms count plus cycles accumulated toward the next ms.
  int m_elapsed;
  int m_phase;
  int m_snap;
  bit m_run;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    m_elapsed = 0; m_phase = 0; m_snap = 0; m_run = 0; m_ovf = 0;
  endtask

  task automatic m_step(input logic [1:0] a, input logic [7:0] d, input logic we, input logic re);
    bit ctrl, tick, wrap;
    ctrl = we && (a == 2'd0);
    tick = 0;
    wrap = 0;
    if (m_run) begin
      m_phase++;
      if (m_phase == P) begin
        tick = 1;
        m_phase = 0;
      end
    end
    if (re && a == 2'd1) m_snap = m_elapsed / 256;
    if (ctrl && d[2]) begin
      m_elapsed = 0;
      m_phase = 0;
    end else if (tick) begin
      m_elapsed = (m_elapsed + 1) % 65536;
      wrap = (m_elapsed == 0);
    end
    if (wrap) m_ovf = 1;
    else if (ctrl && d[3]) m_ovf = 0;
    if (ctrl && d[1]) m_run = 0;
    else if (ctrl && d[0]) m_run = 1;
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {6'b0, m_ovf, m_run};
      2'd1:    return m_elapsed[7:0];
      2'd2:    return m_snap[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // One bus cycle: drive, clock, advance model, release strobes.
  task automatic cyc(input logic [1:0] a, input logic [7:0] d, input logic we, input logic re);
    bus.addr = a; bus.data_in = d; bus.write_en = we; bus.read_en = re;
    @(posedge clk);
    if (reset) m_step(a, d, we, re);
    #1;
    bus.write_en = 1'b0; bus.read_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    cyc(2'd0, d, 1'b1, 1'b0);
  endtask

  // Peek all registers combinationally between edges and compare with model.
  task automatic check_all(input string tag);
    logic [1:0] save;
    save = bus.addr;
    check({tag, ".running"}, running, m_run);
    check({tag, ".overflow"}, overflow, m_ovf);
    for (int a = 0; a < 4; a++) begin
      bus.addr = a[1:0];
      #1;
      check($sformatf("%s.rd%0d", tag, a), bus.data_out, m_read(a[1:0]));
    end
    bus.addr = save;
  endtask

  task automatic peek_lo(output logic [7:0] v);
    bus.addr = 2'd1;
    #1;
    v = bus.data_out;
  endtask

  // Stop, clear, and preload the elapsed count (keeps wrap tests short).
  task automatic preload(input logic [15:0] v);
    ctrl_wr(8'h06);
    force dut.elapsed_q = v;
    idle(1);
    release dut.elapsed_q;
    m_elapsed = v;
  endtask

  logic [7:0] lo, hi;

  initial begin
    bus.addr = 2'd0; bus.data_in = 8'h00; bus.write_en = 1'b0; bus.read_en = 1'b0;
    m_reset();
    #12;
    check("rst.running", running, 1'b0);
    check("rst.overflow", overflow, 1'b0);
    check("rst.status", bus.data_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    check_all("reset");

    // 1: 20 cycles running -> 5 ms
    ctrl_wr(8'h01);
    idle(20);
    peek_lo(lo);
    check("t1.elapsed", lo, 8'd5);
    check("t1.running", running, 1'b1);
    check_all("t1");

    // 2: partial millisecond held across stop/start
    ctrl_wr(8'h06);
    ctrl_wr(8'h01);
    idle(13);
    ctrl_wr(8'h02);
    idle(50);
    peek_lo(lo);
    check("t2.held", lo, 8'd3);
    ctrl_wr(8'h01);
    idle(1);
    peek_lo(lo);
    check("t2.pre", lo, 8'd3);
    idle(1);
    peek_lo(lo);
    check("t2.resume", lo, 8'd4);
    check_all("t2");

    // 3: LO read on the tick edge snapshots the pre-tick HI byte
    ctrl_wr(8'h06);
    ctrl_wr(8'h01);
    idle(1023);
    bus.addr = 2'd1; bus.read_en = 1'b1;
    #1;
    lo = bus.data_out;
    cyc(2'd1, 8'h00, 1'b0, 1'b1);
    bus.addr = 2'd2;
    #1;
    hi = bus.data_out;
    check("t3.pair", {hi, lo}, 16'h00FF);
    check_all("t3");

    // 4: wrap sets overflow, OVF_CLR clears it, wrap beats OVF_CLR
    preload(16'hFFFF);
    ctrl_wr(8'h01);
    idle(4);
    peek_lo(lo);
    check("t4.elapsed", lo, 8'h00);
    check("t4.overflow", overflow, 1'b1);
    bus.addr = 2'd0;
    #1;
    check("t4.status", bus.data_out, 8'h03);
    ctrl_wr(8'h08);
    check("t4.ovfclr", overflow, 1'b0);
    check_all("t4");
    preload(16'hFFFF);
    ctrl_wr(8'h01);
    idle(3);
    ctrl_wr(8'h08);
    check("t4.wrap_beats_clr", overflow, 1'b1);
    check_all("t4b");

    // 5: START|STOP|CLEAR while running; then CLEAR on a tick edge
    ctrl_wr(8'h06);
    ctrl_wr(8'h01);
    idle(36);
    peek_lo(lo);
    check("t5.pre", lo, 8'd9);
    ctrl_wr(8'h07);
    peek_lo(lo);
    check("t5.cleared", lo, 8'd0);
    check("t5.stopped", running, 1'b0);
    ctrl_wr(8'h01);
    idle(3);
    peek_lo(lo);
    check("t5.reload", lo, 8'd0);
    idle(1);
    peek_lo(lo);
    check("t5.first", lo, 8'd1);
    idle(3);
    ctrl_wr(8'h04);
    peek_lo(lo);
    check("t5.clr_tick", lo, 8'd0);
    check_all("t5");

    // 6: asynchronous reset mid-cycle with overflow set
    preload(16'hFFFF);
    ctrl_wr(8'h01);
    idle(6);
    check("t6.ovf_set", overflow, 1'b1);
    bus.addr = 2'd0;
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check("t6.running", running, 1'b0);
    check("t6.overflow", overflow, 1'b0);
    check("t6.status", bus.data_out, 8'h00);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    idle(100);
    peek_lo(lo);
    check("t6.idle", lo, 8'd0);
    check_all("t6");

    // Random bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] a;
      logic [7:0] d;
      logic we, re;
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      we = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) == 0);
      if (we && a == 2'd0 && d[1] && $urandom_range(0, 1) == 1) d[1] = 1'b0;
      cyc(a, d, we, re);
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
